// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int DEF_WIDTH_N = 32;
  localparam int DEF_WIDTH_D = 16;
  localparam int CNT_W       = $clog2(DEF_WIDTH_N);

  localparam logic [DEF_WIDTH_N-1:0] DBZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for seq_restoring_divider.
// Macro DIV_OVF_EN adds the ovf result flag.
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_N-1:0] dividend;
  logic [WIDTH_D-1:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;
  logic               dbz;
`ifdef DIV_OVF_EN
  logic               ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz, ovf
  );
`else
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz
  );
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor,
// keep the difference only when the subtract does not borrow.
module div_step #(
  parameter int WIDTH_D = 16
) (
  input  logic [WIDTH_D-1:0] r,
  input  logic               n_msb,
  input  logic [WIDTH_D-1:0] divisor,
  output logic [WIDTH_D-1:0] r_next,
  output logic               q_bit
);

  logic [WIDTH_D:0]   t;
  logic [WIDTH_D+1:0] sum;
  logic               unused_sum_msb;

  assign t = {r, n_msb};

  // t + ~d + 1 at WIDTH_D+1 bits; the carry out is set exactly when t >= divisor
  assign sum = {1'b0, t} + {1'b0, ~{1'b0, divisor}} + (WIDTH_D+2)'(1);

  assign q_bit  = sum[WIDTH_D+1];
  assign r_next = q_bit ? sum[WIDTH_D-1:0] : t[WIDTH_D-1:0];

  // r < divisor on entry, so the kept value always fits WIDTH_D bits
  assign unused_sum_msb = sum[WIDTH_D];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_OVF_EN to add the ovf flag (quotient wider than WIDTH_D bits, or divide-by-zero).
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid; operands latched on acceptance
// CALC  | WIDTH_N iterations, count runs WIDTH_N-1 down to 0
// DONE  | out_valid=1, result held until out_ready
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH_N = DEF_WIDTH_N,
  parameter int WIDTH_D = DEF_WIDTH_D
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH_N);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH_N-1:0] n_sh;
  logic [WIDTH_N-1:0] n_nxt;
  logic [WIDTH_D-1:0] r_q;
  logic [WIDTH_D-1:0] r_nxt;
  logic [WIDTH_D-1:0] div_q;
  logic               q_bit;
  logic               dbz_q;
  logic               div_zero;
`ifdef DIV_OVF_EN
  logic               ovf_q;
`endif

  div_step #(.WIDTH_D(WIDTH_D)) u_step (
    .r       (r_q),
    .n_msb   (n_sh[WIDTH_N-1]),
    .divisor (div_q),
    .r_next  (r_nxt),
    .q_bit   (q_bit)
  );

  assign div_zero = (bus.divisor == '0);

  // dividend shifts out the top while quotient bits shift in at the bottom
  assign n_nxt = {n_sh[WIDTH_N-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      n_sh  <= '0;
      r_q   <= '0;
      div_q <= '0;
      dbz_q <= 1'b0;
`ifdef DIV_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            div_q <= bus.divisor;
            cnt   <= CW'(WIDTH_N - 1);
            dbz_q <= div_zero;
            if (div_zero) begin
              n_sh <= '1;
              r_q  <= bus.dividend[WIDTH_D-1:0];
            end else begin
              n_sh <= bus.dividend;
              r_q  <= '0;
            end
`ifdef DIV_OVF_EN
            ovf_q <= div_zero;
`endif
          end
        end
        CALC: begin
          n_sh <= n_nxt;
          r_q  <= r_nxt;
          cnt  <= cnt - CW'(1);
`ifdef DIV_OVF_EN
          if (cnt == '0) begin
            ovf_q <= ((n_nxt >> WIDTH_D) != '0);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = n_sh;
  assign bus.remainder = r_q;
  assign bus.dbz       = dbz_q;
`ifdef DIV_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vectors, backpressure,
// mid-operation reset and randomized operands against an arithmetic reference.
module tb_seq_restoring_divider;
  import div_pkg::*;

  localparam int WN = DEF_WIDTH_N;
  localparam int WD = DEF_WIDTH_D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH_N(WN), .WIDTH_D(WD)) dif ();

  seq_restoring_divider #(.WIDTH_N(WN), .WIDTH_D(WD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the fixed divide-by-zero result
  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [31:0] q, output logic [15:0] r,
                       output logic z, output logic o, output int lat);
    if (b == 16'd0) begin
      q = 32'hFFFF_FFFF;
      r = a[15:0];
      z = 1'b1;
      o = 1'b1;
      lat = 1;
    end else begin
      q = a / {16'd0, b};
      r = 16'(a % {16'd0, b});
      z = 1'b0;
      o = (q > 32'h0000_FFFF);
      lat = WN + 1;
    end
  endtask

  // mode 0: out_ready high at once; 1: random ready and in_valid noise; 2: ready low for hold clocks
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int mode, input int hold,
                        output logic [31:0] q, output logic [15:0] r,
                        output logic z, output logic o, output int lat);
    int  guard;
    bit  rdy;
    @(negedge clk);
    dif.in_valid  = 1'b1;
    dif.dividend  = a;
    dif.divisor   = b;
    dif.out_ready = 1'b0;
    guard = 0;
    while (!dif.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_at_issue", 64'(dif.in_ready), 64'd1);
    @(posedge clk);
    lat = 1;
    #1;
    while (!dif.out_valid && lat < WN + 10) begin
      dif.in_valid  = (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
      dif.dividend  = $urandom;
      dif.divisor   = 16'($urandom);
      dif.out_ready = (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk);
      lat++;
      #1;
    end
    dif.in_valid = (mode == 2);
    dif.dividend = $urandom;
    dif.divisor  = 16'($urandom);
    q = dif.quotient;
    r = dif.remainder;
    z = dif.dbz;
`ifdef DIV_OVF_EN
    o = dif.ovf;
`else
    o = 1'b0;
`endif
    guard = 0;
    do begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(1));
        default: rdy = (guard >= hold);
      endcase
      if (mode == 1) dif.in_valid = 1'($urandom_range(1));
      dif.out_ready = rdy;
      @(posedge clk);
      #1;
      guard++;
      if (rdy) begin
        check("out_valid_after_pop", 64'(dif.out_valid), 64'd0);
        check("in_ready_after_pop", 64'(dif.in_ready), 64'd1);
      end else begin
        check("out_valid_held", 64'(dif.out_valid), 64'd1);
        check("in_ready_in_done", 64'(dif.in_ready), 64'd0);
        check("quotient_held", 64'(dif.quotient), 64'(q));
        check("remainder_held", 64'(dif.remainder), 64'(r));
      end
      dif.in_valid = 1'b0;
    end while (!rdy && guard < 200);
    dif.out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v,
                              input logic [31:0] q, input logic [15:0] r,
                              input logic z, input logic o, input int lat);
    check({tag, "_quotient"}, 64'(q), 64'(v.q));
    check({tag, "_remainder"}, 64'(r), 64'(v.r));
    check({tag, "_dbz"}, 64'(z), 64'(v.z));
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
`ifdef DIV_OVF_EN
    check({tag, "_ovf"}, 64'(o), 64'(v.o));
`else
    if (o !== 1'b0) check({tag, "_ovf_absent"}, 64'(o), 64'd0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, a;
    logic [15:0] r, b;
    logic        z, o;
    int          lat;
    vec_t        v;

    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b0;

    #12;
    check("reset_in_ready", 64'(dif.in_ready), 64'd1);
    check("reset_out_valid", 64'(dif.out_valid), 64'd0);
    check("reset_quotient", 64'(dif.quotient), 64'd0);
    check("reset_remainder", 64'(dif.remainder), 64'd0);
    check("reset_dbz", 64'(dif.dbz), 64'd0);
`ifdef DIV_OVF_EN
    check("reset_ovf", 64'(dif.ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = '{a: 32'd100,        b: 16'd7,      q: 32'd14,        r: 16'd2,      z: 1'b0, o: 1'b0, lat: 33};
    vecs[1]  = '{a: 32'hFFFF_FFFF,  b: 16'hFFFF,   q: 32'h0001_0001, r: 16'h0000,   z: 1'b0, o: 1'b1, lat: 33};
    vecs[2]  = '{a: 32'h0000_1234,  b: 16'd0,      q: 32'hFFFF_FFFF, r: 16'h1234,   z: 1'b1, o: 1'b1, lat: 1};
    vecs[3]  = '{a: 32'd50,         b: 16'd5,      q: 32'd10,        r: 16'd0,      z: 1'b0, o: 1'b0, lat: 33};
    vecs[4]  = '{a: 32'd5,          b: 16'd9,      q: 32'd0,         r: 16'd5,      z: 1'b0, o: 1'b0, lat: 33};
    vecs[5]  = '{a: 32'hDEAD_BEEF,  b: 16'd1,      q: 32'hDEAD_BEEF, r: 16'd0,      z: 1'b0, o: 1'b1, lat: 33};
    vecs[6]  = '{a: 32'd0,          b: 16'hFFFF,   q: 32'd0,         r: 16'd0,      z: 1'b0, o: 1'b0, lat: 33};
    vecs[7]  = '{a: 32'hFFFE_0001,  b: 16'hFFFF,   q: 32'h0000_FFFF, r: 16'd0,      z: 1'b0, o: 1'b0, lat: 33};
    vecs[8]  = '{a: 32'h0000_FFFF,  b: 16'h0100,   q: 32'h0000_00FF, r: 16'h00FF,   z: 1'b0, o: 1'b0, lat: 33};
    vecs[9]  = '{a: 32'd1000000,    b: 16'd3,      q: 32'd333333,    r: 16'd1,      z: 1'b0, o: 1'b1, lat: 33};
    vecs[10] = '{a: 32'hFFFF_FFFF,  b: 16'd0,      q: 32'hFFFF_FFFF, r: 16'hFFFF,   z: 1'b1, o: 1'b1, lat: 1};

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, 0, q, r, z, o, lat);
      check_result($sformatf("vec%0d", i), vecs[i], q, r, z, o, lat);
    end

    // backpressure: ready low for 5 clocks in DONE with in_valid asserted, taken on the 6th
    run_op(32'd100, 16'd7, 2, 5, q, r, z, o, lat);
    check_result("backpressure", vecs[0], q, r, z, o, lat);

    // reset during iteration 10
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = 32'h1234_5678;
    dif.divisor  = 16'h0123;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy_before_reset", 64'(dif.in_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(dif.out_valid), 64'd0);
    check("abort_in_ready", 64'(dif.in_ready), 64'd1);
    check("abort_quotient", 64'(dif.quotient), 64'd0);
    check("abort_dbz", 64'(dif.dbz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd50, 16'd5, 0, 0, q, r, z, o, lat);
    check_result("after_reset", vecs[3], q, r, z, o, lat);

    for (int i = 0; i < 1200; i++) begin
      case ($urandom_range(9))
        0: begin a = $urandom; b = 16'd0; end
        1: begin a = $urandom; b = 16'd1; end
        2: begin b = 16'($urandom_range(1, 65535)); a = $urandom_range(0, 32'(b) - 1); end
        3: begin a = $urandom; b = 16'hFFFF; end
        4: begin a = $urandom; b = 16'($urandom_range(1, 255)); end
        default: begin a = $urandom; b = 16'($urandom); end
      endcase
      model(a, b, v.q, v.r, v.z, v.o, v.lat);
      v.a = a;
      v.b = b;
      run_op(a, b, 1, 0, q, r, z, o, lat);
      check_result($sformatf("rnd%0d", i), v, q, r, z, o, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
